nat_ingress_pkt_fifo: RTL and testbench

- Store-and-forward AXI-Stream packet FIFO that sits directly upstream of the NAT connection-tracking stage.
- That stage deasserts tready for several cycles per TCP packet while it hashes and probes. This block absorbs those stalls so the line-rate source, which cannot be backpressured, never loses beats mid-frame.
- Only complete frames are forwarded. A frame that cannot fit is dropped whole and counted.

---
 rtl/nat_ingress_pkt_fifo.sv | 116 +++++++++++
 tb/tb_nat_ingress_pkt_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nat_ingress_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO ahead of NAT connection tracking.
// Absorbs downstream stalls; frames that do not fit are dropped whole and counted.
module nat_ingress_pkt_fifo #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           drop_cnt
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {ST_RESYNC, ST_PASS, ST_DROP} st_e;

  st_e               state_q, state_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   wr_commit_q, wr_commit_d;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [31:0]       drop_q, drop_d;
  logic [DATA_W-1:0] m_data_q;
  logic [KEEP_W-1:0] m_keep_q;
  logic              m_last_q, m_vld_q;
  logic [ADDR_W:0]   used;
  logic              full, wr_en, load;

  // The beat sitting in the output register has already left [rd_ptr, wr_ptr).
  assign used = wr_ptr_q - rd_ptr_q;
  assign full = (used == DEPTH_P);
  assign load = (!m_vld_q || m_axis_tready) && (rd_ptr_q != wr_commit_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_d      = drop_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_RESYNC: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_PASS;
      end
      ST_PASS: begin
        if (s_axis_tvalid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast) wr_commit_d = wr_ptr_q + 1'b1;
          end else begin
            // Overflow: discard the partial frame back to the last frame boundary.
            wr_ptr_d = wr_commit_q;
            drop_d   = drop_q + 32'd1;
            if (!s_axis_tlast) state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_PASS;
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESYNC;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      m_data_q <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
      m_vld_q  <= 1'b0;
    end else if (load) begin
      {m_data_q, m_keep_q, m_last_q} <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      m_vld_q  <= 1'b1;
      rd_ptr_q <= rd_ptr_q + 1'b1;
    end else if (m_axis_tready) begin
      m_vld_q  <= 1'b0;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tvalid = m_vld_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_nat_ingress_pkt_fifo.sv
// Scoreboard bench: two instances (64-deep and 16-deep) share the ingress bus;
// a negedge monitor pops expected beats and checks AXI hold behaviour.
module tb_nat_ingress_pkt_fifo;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l;} beat_t;

  logic        clk, rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast, drv_vld;
  logic [1:0]  mask;
  logic        tready6, tready4, rnd_rdy;
  logic        s_tvalid6, s_tvalid4, s_tready6, s_tready4;
  logic [63:0] m_tdata6, m_tdata4;
  logic [7:0]  m_tkeep6, m_tkeep4;
  logic        m_tlast6, m_tlast4, m_tvalid6, m_tvalid4;
  logic [31:0] drop6, drop4;

  beat_t q6[$], q4[$];
  int checks = 0, failures = 0, fid = 0;

  assign s_tvalid6 = drv_vld & mask[0];
  assign s_tvalid4 = drv_vld & mask[1];

  nat_ingress_pkt_fifo #(.ADDR_W(6), .DATA_W(64)) u_dut6 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(s_tvalid6), .s_axis_tready(s_tready6),
    .m_axis_tdata(m_tdata6), .m_axis_tkeep(m_tkeep6), .m_axis_tlast(m_tlast6),
    .m_axis_tvalid(m_tvalid6), .m_axis_tready(tready6), .drop_cnt(drop6));

  nat_ingress_pkt_fifo #(.ADDR_W(4), .DATA_W(64)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .s_axis_tvalid(s_tvalid4), .s_axis_tready(s_tready4),
    .m_axis_tdata(m_tdata4), .m_axis_tkeep(m_tkeep4), .m_axis_tlast(m_tlast4),
    .m_axis_tvalid(m_tvalid4), .m_axis_tready(tready4), .drop_cnt(drop4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake plus output stability under stall.
  logic       stall6 = 1'b0, stall4 = 1'b0;
  logic [73:0] hold6, hold4;
  always @(negedge clk) begin
    if (rst) begin
      stall6 = 1'b0;
      stall4 = 1'b0;
    end else begin
      if (stall6) chk("hold6", 80'({m_tvalid6, m_tdata6, m_tkeep6, m_tlast6}), 80'(hold6));
      if (stall4) chk("hold4", 80'({m_tvalid4, m_tdata4, m_tkeep4, m_tlast4}), 80'(hold4));
      if (m_tvalid6 && tready6) begin
        if (q6.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected6 actual=%h required=none", {m_tdata6, m_tkeep6, m_tlast6});
        end else chk("beat6", 80'({m_tdata6, m_tkeep6, m_tlast6}), 80'(q6.pop_front()));
      end
      if (m_tvalid4 && tready4) begin
        if (q4.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected4 actual=%h required=none", {m_tdata4, m_tkeep4, m_tlast4});
        end else chk("beat4", 80'({m_tdata4, m_tkeep4, m_tlast4}), 80'(q4.pop_front()));
      end
      stall6 = m_tvalid6 && !tready6;
      stall4 = m_tvalid4 && !tready4;
      hold6  = {m_tvalid6, m_tdata6, m_tkeep6, m_tlast6};
      hold4  = {m_tvalid4, m_tdata4, m_tkeep4, m_tlast4};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) tready6 = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic [1:0] m, input int b, input logic [7:0] k, input logic l);
    mask    = m;
    tdata   = {32'(fid), 32'(b)};
    tkeep   = k;
    tlast   = l;
    drv_vld = 1'b1;
  endtask

  task automatic send(input logic [1:0] m, input int n, input logic [7:0] lastkeep,
                      input bit push, input int gap_max);
    fid++;
    for (int b = 0; b < n; b++) begin
      drive(m, b, (b == n - 1) ? lastkeep : 8'hFF, b == n - 1);
      if (push && m[0]) q6.push_back({tdata, tkeep, tlast});
      if (push && m[1]) q4.push_back({tdata, tkeep, tlast});
      tick();
      if (gap_max > 0) begin
        drv_vld = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
    drv_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((q6.size() != 0 || q4.size() != 0 || m_tvalid6 || m_tvalid4) && i < 3000) begin
      tick();
      i++;
    end
    if (i == 3000) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d/%0d required=0/0", q6.size(), q4.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; drv_vld = 1'b0; mask = 2'b00; tdata = '0; tkeep = '0; tlast = 1'b0;
    tready6 = 1'b1; tready4 = 1'b1; rnd_rdy = 1'b0;
    repeat (3) tick();
    chk("reset_out6", 80'({m_tvalid6, m_tdata6, m_tkeep6, m_tlast6}), 80'd0);
    chk("reset_drop", 80'({drop6, drop4}), 80'd0);
    chk("s_tready", 80'({s_tready6, s_tready4}), 80'b11);
    rst = 1'b0;

    // One-beat frame on both instances to leave RESYNC; it must not appear.
    send(2'b11, 1, 8'hFF, 1'b0, 0);
    repeat (4) tick();

    // Single 8-beat frame: tvalid rises one edge after the tlast edge, no gaps.
    send(2'b01, 8, 8'h0F, 1'b1, 0);
    chk("latency_lo", 80'(m_tvalid6), 80'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("contig1", 80'(m_tvalid6), 80'd1);
      tick();
    end
    chk("idle1", 80'(m_tvalid6), 80'd0);
    chk("drop6_t1", 80'(drop6), 80'd0);

    // Three frames buffered behind a 30-cycle stall, then drained contiguously.
    tready6 = 1'b0;
    send(2'b01, 8, 8'hFF, 1'b1, 0);
    send(2'b01, 8, 8'h01, 1'b1, 0);
    send(2'b01, 8, 8'h3C, 1'b1, 0);
    repeat (6) tick();
    tready6 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      chk("contig2", 80'(m_tvalid6), 80'd1);
      tick();
    end
    chk("idle2", 80'(m_tvalid6), 80'd0);
    chk("drop6_t2", 80'(drop6), 80'd0);

    // 16-deep: A fits, B's tenth beat finds the FIFO full, B is rolled back.
    tready4 = 1'b0;
    send(2'b10, 8, 8'h07, 1'b1, 0);
    send(2'b10, 10, 8'hFF, 1'b0, 0);
    tick();
    chk("drop4_rollback", 80'(drop4), 80'd1);
    tready4 = 1'b1;
    wait_drain();
    send(2'b10, 8, 8'hF0, 1'b1, 0);
    wait_drain();
    chk("drop4_after_c", 80'(drop4), 80'd1);

    // 16-deep: 20-beat frame can never fit; following frame passes.
    send(2'b10, 20, 8'hFF, 1'b0, 0);
    repeat (5) tick();
    chk("drop4_oversize", 80'(drop4), 80'd2);
    send(2'b10, 4, 8'h1F, 1'b1, 0);
    wait_drain();

    // Reset while a beat is held in the output register and a frame is mid-flight.
    tready6 = 1'b0;
    send(2'b01, 3, 8'hFF, 1'b1, 0);
    repeat (2) tick();
    fid++;
    for (int b = 0; b < 3; b++) begin
      drive(2'b01, b, 8'hFF, 1'b0);
      tick();
    end
    rst = 1'b1;
    drive(2'b01, 3, 8'hFF, 1'b0);
    tick();
    q6.delete();
    chk("rst_out6", 80'({m_tvalid6, m_tdata6, m_tkeep6, m_tlast6}), 80'd0);
    chk("rst_drop", 80'({drop6, drop4}), 80'd0);
    rst = 1'b0;
    tready6 = 1'b1;
    drive(2'b11, 4, 8'hFF, 1'b0);
    tick();
    drive(2'b11, 5, 8'h0F, 1'b1);
    tick();
    drv_vld = 1'b0;
    repeat (4) tick();
    chk("rst_no_partial", 80'(m_tvalid6), 80'd0);
    send(2'b01, 5, 8'h03, 1'b1, 0);
    wait_drain();
    chk("drop6_t5", 80'(drop6), 80'd0);

    // Random backpressure, 200 frames of 1..10 beats; admission keeps it loss-free.
    rnd_rdy = 1'b1;
    for (int f = 0; f < 200; f++) begin
      int w = 0;
      while (q6.size() > 40 && w < 2000) begin
        tick();
        w++;
      end
      send(2'b01, $urandom_range(1, 10), 8'($urandom_range(1, 255)), 1'b1, 2);
    end
    rnd_rdy = 1'b0;
    tready6 = 1'b1;
    wait_drain();
    chk("drop6_rand", 80'(drop6), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
